// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master = producer of operands and consumer of results, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic [3:0]       ALU_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outputC;
  logic [3:0]       ALU_flags;
  logic             div_by_zero;

  modport master (
    output in_valid, inputA, inputB, ALU_control, out_ready,
    input  in_ready, out_valid, outputC, ALU_flags, div_by_zero
  );

  modport slave (
    input  in_valid, inputA, inputB, ALU_control, out_ready,
    output in_ready, out_valid, outputC, ALU_flags, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with an iterative restoring divider,
// valid/ready handshake on both sides and {N,Z,C,V} + divide-by-zero flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no result held, ready for a new operation
// DIV_BUSY | one restoring-division step per cycle, input stalled
// DONE     | result valid, waiting for the consumer to take it
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0101;
  localparam logic [3:0] OP_SR  = 4'b0110;
  localparam logic [3:0] OP_AVG = 4'b0111;

  state_t           state;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             dbz;
  logic             res_valid;

  // divider working registers: quo starts as the dividend and shifts
  // quotient bits in from the right as dividend bits leave on the left
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             is_div;
  logic             b_zero;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] mul_full;
  logic [9:0]         avg_sum;
  logic [7:0]         avg_quo;
  logic [WIDTH-1:0]   op_res;
  logic               op_c;
  logic               op_v;

  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign bus.in_ready    = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign bus.out_valid   = res_valid;
  assign bus.outputC     = result;
  assign bus.ALU_flags   = flags;
  assign bus.div_by_zero = dbz;

  assign accept = bus.in_valid && bus.in_ready;
  assign is_div = (bus.ALU_control == OP_DIV);
  assign b_zero = (bus.inputB == '0);

  assign add_full = {1'b0, bus.inputA} + {1'b0, bus.inputB};
  assign sub_full = {1'b0, bus.inputA} - {1'b0, bus.inputB};
  assign mul_full = {{WIDTH{1'b0}}, bus.inputA} * {{WIDTH{1'b0}}, bus.inputB};
  assign avg_sum  = {2'b00, bus.inputA[7:0]} + {2'b00, bus.inputA[15:8]}
                  + {2'b00, bus.inputA[23:16]};
  assign avg_quo  = 8'(avg_sum / 10'd3);

  // single-cycle operation result and carry/overflow
  always_comb begin
    op_res = bus.inputA;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (bus.ALU_control)
      OP_ADD: begin
        op_res = add_full[WIDTH-1:0];
        op_c   = add_full[WIDTH];
        op_v   = (bus.inputA[WIDTH-1] == bus.inputB[WIDTH-1]) &&
                 (add_full[WIDTH-1] != bus.inputA[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = sub_full[WIDTH-1:0];
        op_c   = !sub_full[WIDTH];
        op_v   = (bus.inputA[WIDTH-1] != bus.inputB[WIDTH-1]) &&
                 (sub_full[WIDTH-1] != bus.inputA[WIDTH-1]);
      end
      OP_MUL: begin
        op_res = mul_full[WIDTH-1:0];
        op_v   = |mul_full[2*WIDTH-1:WIDTH];
      end
      OP_SL:   op_res = (bus.inputB >= WIDTH_VAL) ? '0 : (bus.inputA << bus.inputB);
      OP_SR:   op_res = (bus.inputB >= WIDTH_VAL) ? '0 : (bus.inputA >> bus.inputB);
      OP_AVG:  op_res = {{(WIDTH-8){1'b0}}, avg_quo};
      default: op_res = bus.inputA;
    endcase
  end

  // one restoring-division step: bring down the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, divisor});
    rem_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], rem_ge};
  end

  // control FSM with registered result, flags and out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      flags     <= '0;
      dbz       <= 1'b0;
      res_valid <= 1'b0;
      quo       <= '0;
      divisor   <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_div && b_zero) begin
              result    <= '1;
              flags     <= 4'b1000;
              dbz       <= 1'b1;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (is_div) begin
              quo       <= bus.inputA;
              divisor   <= bus.inputB;
              rem       <= '0;
              cnt       <= CNT_START;
              res_valid <= 1'b0;
              state     <= DIV_BUSY;
            end else begin
              result    <= op_res;
              flags     <= {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
              dbz       <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DIV_BUSY: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result    <= quo_nxt;
            flags     <= {quo_nxt[WIDTH-1], (quo_nxt == '0), 2'b00};
            dbz       <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results come from a behavioural
// model when an operation is driven and are compared when the DUT delivers.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  f;
    logic        dz;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb[$];

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    logic [63:0] wide;
    longint s;
    int     avg;
    r = '0;
    case (op)
      4'd1: begin
        wide   = 64'(a) + 64'(b);
        r.c    = wide[31:0];
        r.f[1] = wide[32];
        s      = longint'($signed(a)) + longint'($signed(b));
        r.f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: begin
        r.c    = a - b;
        r.f[1] = (a >= b);
        s      = longint'($signed(a)) - longint'($signed(b));
        r.f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        wide   = 64'(a) * 64'(b);
        r.c    = wide[31:0];
        r.f[0] = (wide[63:32] != 0);
      end
      4'd4: begin
        if (b == 0) begin
          r.c = 32'hFFFF_FFFF;
          r.dz = 1'b1;
        end else begin
          r.c = a / b;
        end
      end
      4'd5: r.c = (b >= 32) ? 32'd0 : (a << b);
      4'd6: r.c = (b >= 32) ? 32'd0 : (a >> b);
      4'd7: begin
        avg = (int'(a[7:0]) + int'(a[15:8]) + int'(a[23:16])) / 3;
        r.c = 32'(avg);
      end
      default: r.c = a;
    endcase
    r.f[3] = r.c[31];
    r.f[2] = (r.c == 0);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one op (expected pushed), wait for its result, hand it off
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output res_t obs, output int lat);
    int w;
    sb.push_back(model(op, a, b));
    bus.ALU_control = op;
    bus.inputA      = a;
    bus.inputB      = b;
    bus.in_valid    = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      step();
      w++;
    end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      step();
      lat++;
    end
    obs = {bus.outputC, bus.ALU_flags, bus.div_by_zero};
    if (bus.out_ready) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.inputA = '0;
    bus.inputB = '0;
    bus.ALU_control = '0;
    step();
    step();
    n_checks++;
    if ({bus.outputC, bus.ALU_flags, bus.div_by_zero, bus.out_valid} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got C=%h F=%b DZ=%b OV=%b, expected all zero",
               bus.outputC, bus.ALU_flags, bus.div_by_zero, bus.out_valid);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops[5] = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd2};
    logic [31:0] as[5]  = '{32'h7FFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs[5]  = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd1};
    res_t obs, exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], obs, lat);
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp || lat != 0) begin
        n_fail++;
        $display("FAIL add_sub[%0d]: got C=%h F=%b DZ=%b lat=%0d, expected C=%h F=%b DZ=%b lat=0",
                 i, obs.c, obs.f, obs.dz, lat, exp.c, exp.f, exp.dz);
      end
    end
  endtask

  task automatic test_mul_shift();
    logic [3:0]  ops[6] = '{4'd3, 4'd3, 4'd5, 4'd6, 4'd5, 4'd6};
    logic [31:0] as[6]  = '{32'h0001_0000, 32'd1234, 32'd1, 32'h8000_0000, 32'h0000_00F1, 32'hFFFF_FFFF};
    logic [31:0] bs[6]  = '{32'h0001_0000, 32'd5678, 32'd32, 32'd31, 32'd4, 32'd40};
    res_t obs, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], obs, lat);
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp || lat != 0) begin
        n_fail++;
        $display("FAIL mul_shift[%0d]: got C=%h F=%b DZ=%b lat=%0d, expected C=%h F=%b DZ=%b lat=0",
                 i, obs.c, obs.f, obs.dz, lat, exp.c, exp.f, exp.dz);
      end
    end
  endtask

  task automatic test_div();
    res_t obs, exp;
    int   busy;
    bit   rdy_seen;
    int   lat;
    // DIV 100/7 with a distracting op held on in_valid while busy
    sb.push_back(model(4'd4, 32'd100, 32'd7));
    bus.ALU_control = 4'd4;
    bus.inputA = 32'd100;
    bus.inputB = 32'd7;
    bus.in_valid = 1'b1;
    step();
    bus.ALU_control = 4'd0;
    bus.inputA = 32'hDEAD_BEEF;
    busy = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && busy < 40) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      step();
      busy++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (busy != 32 || rdy_seen) begin
      n_fail++;
      $display("FAIL div_timing: got busy=%0d in_ready_seen=%b, expected busy=32 in_ready_seen=0", busy, rdy_seen);
    end
    obs = {bus.outputC, bus.ALU_flags, bus.div_by_zero};
    step();
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL div_100_7: got C=%h F=%b DZ=%b, expected C=%h F=%b DZ=%b",
               obs.c, obs.f, obs.dz, exp.c, exp.f, exp.dz);
    end
    // divide by zero: immediate result
    run_op(4'd4, 32'd9, 32'd0, obs, lat);
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || lat != 0) begin
      n_fail++;
      $display("FAIL div_by_zero: got C=%h F=%b DZ=%b lat=%0d, expected C=%h F=%b DZ=%b lat=0",
               obs.c, obs.f, obs.dz, lat, exp.c, exp.f, exp.dz);
    end
    // next non-div0 result clears div_by_zero; also large quotient and zero quotient
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, obs, lat);
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || lat != 32) begin
      n_fail++;
      $display("FAIL div_max: got C=%h F=%b DZ=%b lat=%0d, expected C=%h F=%b DZ=%b lat=32",
               obs.c, obs.f, obs.dz, lat, exp.c, exp.f, exp.dz);
    end
    run_op(4'd4, 32'd5, 32'd9, obs, lat);
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL div_small: got C=%h F=%b DZ=%b, expected C=%h F=%b DZ=%b",
               obs.c, obs.f, obs.dz, exp.c, exp.f, exp.dz);
    end
  endtask

  task automatic test_backpressure();
    res_t obs, exp;
    bit   stable;
    int   lat;
    bus.out_ready = 1'b0;
    sb.push_back(model(4'd1, 32'd2, 32'd3));
    bus.ALU_control = 4'd1;
    bus.inputA = 32'd2;
    bus.inputB = 32'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    obs = {bus.outputC, bus.ALU_flags, bus.div_by_zero};
    stable = bus.out_valid;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          {bus.outputC, bus.ALU_flags, bus.div_by_zero} !== obs) stable = 1'b0;
      step();
    end
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || !stable) begin
      n_fail++;
      $display("FAIL backpressure_hold: got C=%h F=%b DZ=%b stable=%b, expected C=%h F=%b DZ=%b stable=1",
               obs.c, obs.f, obs.dz, stable, exp.c, exp.f, exp.dz);
    end
    // hand off and accept ADD 1+1 in the same cycle
    bus.out_ready = 1'b1;
    run_op(4'd1, 32'd1, 32'd1, obs, lat);
    exp = sb.pop_front();
    n_checks++;
    if (obs !== exp || lat != 0) begin
      n_fail++;
      $display("FAIL backpressure_replace: got C=%h F=%b DZ=%b lat=%0d, expected C=%h F=%b DZ=%b lat=0",
               obs.c, obs.f, obs.dz, lat, exp.c, exp.f, exp.dz);
    end
  endtask

  task automatic test_avg();
    logic [31:0] as[3] = '{32'h0030_6090, 32'h00FF_FFFF, 32'h1200_0001};
    res_t obs, exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(4'd7, as[i], 32'd0, obs, lat);
      exp = sb.pop_front();
      n_checks++;
      if (obs !== exp || lat != 0) begin
        n_fail++;
        $display("FAIL avg[%0d]: got C=%h F=%b lat=%0d, expected C=%h F=%b lat=0",
                 i, obs.c, obs.f, lat, exp.c, exp.f);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t obs, exp;
    int   good;
    bit   ready_ok;
    logic [3:0]  op;
    logic [31:0] a;
    good = 0;
    ready_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'd0 : 4'(8 + i);
      a  = $urandom;
      sb.push_back(model(op, a, 32'h1234_5678));
      bus.ALU_control = op;
      bus.inputA = a;
      bus.inputB = 32'h1234_5678;
      bus.in_valid = 1'b1;
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      step();
      obs = {bus.outputC, bus.ALU_flags, bus.div_by_zero};
      exp = sb.pop_front();
      if (bus.out_valid === 1'b1 && obs === exp) good++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (good != 8 || !ready_ok) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d consecutive matches ready_ok=%b, expected 8 and 1", good, ready_ok);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    bit stale;
    bus.ALU_control = 4'd4;
    bus.inputA = 32'd100;
    bus.inputB = 32'd7;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.outputC, bus.ALU_flags, bus.div_by_zero, bus.out_valid} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got C=%h F=%b DZ=%b OV=%b, expected all zero",
               bus.outputC, bus.ALU_flags, bus.div_by_zero, bus.out_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_div_ready: got in_ready=%b, expected 1", bus.in_ready);
    end
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL reset_mid_div_stale: got a result after abort, expected none");
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul_shift();
    test_div();
    test_backpressure();
    test_avg();
    test_back_to_back();
    test_reset_mid_div();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d leftover entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
